fpu_issue_queue: RTL and testbench

FPU_ISSUE_QUEUE -- requirements
Module: fpu_issue_queue

---
 rtl/fpu_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 53 +++++
 rtl/fpu_issue_queue.sv | 135 +++++++++++++
 tb/tb_fpu_issue_queue.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue queue: opcodes, sizing defaults and
// the output-credit rule that protects the non-stallable FPU result path.
package fpu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } fpu_op_e;

  localparam int unsigned IN_DEPTH_DEF = 4;
  localparam int unsigned TAG_W_DEF    = 4;
  localparam int unsigned OUT_DEPTH    = 3;

  // An issue is allowed only if every op already past the input FIFO
  // (ISS, WB, output FIFO) still fits in the output FIFO once this cycle's
  // response pop is accounted for.
  function automatic logic credit_ok(input logic       iss_v,
                                     input logic       wb_v,
                                     input logic [1:0] out_cnt,
                                     input logic       fire);
    logic [2:0] occ;
    occ = {2'b00, iss_v} + {2'b00, wb_v} + {1'b0, out_cnt};
    return occ < (3'(OUT_DEPTH) + {2'b00, fire});
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with arbitrary (non power-of-two) depth. Writes when full
// and reads when empty are ignored; simultaneous read and write both apply.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_wr   = wr_en && (count != CNT_W'(DEPTH));
  assign do_rd   = rd_en && (count != '0);
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= ptr_next(wr_ptr);
      if (do_rd) rd_ptr <= ptr_next(rd_ptr);
      if (do_wr && !do_rd)      count <= count + 1'b1;
      else if (!do_wr && do_rd) count <= count - 1'b1;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fpu_issue_queue.sv
// Issue queue in front of an external, non-stallable, one-cycle FPU.
// Requests are buffered, issued only when the output FIFO is guaranteed room
// for the result, and returned in acceptance order with op and tag attached.
module fpu_issue_queue
  import fpu_pkg::*;
#(
  parameter int unsigned IN_DEPTH = IN_DEPTH_DEF,
  parameter int unsigned TAG_W    = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [1:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  output logic [1:0]       fpu_opcode,
  input  logic [31:0]      fpu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [1:0]       rsp_op,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  localparam int unsigned IN_W      = 66 + TAG_W;
  localparam int unsigned OUT_W     = 34 + TAG_W;
  localparam int unsigned IN_CNT_W  = $clog2(IN_DEPTH + 1);
  localparam int unsigned OUT_CNT_W = $clog2(OUT_DEPTH + 1);

  logic [IN_W-1:0]      in_rdata;
  logic [IN_CNT_W-1:0]  in_count;
  logic                 in_empty;
  logic [OUT_W-1:0]     out_rdata;
  logic [OUT_CNT_W-1:0] out_count;
  logic                 out_empty;

  logic                 push;
  logic                 rsp_fire;
  logic                 issue;

  logic                 iss_valid;
  logic [31:0]          iss_a;
  logic [31:0]          iss_b;
  logic [1:0]           iss_op;
  logic [TAG_W-1:0]     iss_tag;

  logic                 wb_valid;
  logic [1:0]           wb_op;
  logic [TAG_W-1:0]     wb_tag;

  assign req_ready = (in_count < IN_CNT_W'(IN_DEPTH)) && !rst;
  assign push      = req_valid && req_ready;
  assign rsp_valid = !out_empty;
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign issue     = !in_empty && credit_ok(iss_valid, wb_valid, out_count, rsp_fire);

  sync_fifo #(
    .WIDTH (IN_W),
    .DEPTH (IN_DEPTH)
  ) u_in_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data ({req_a, req_b, req_op, req_tag}),
    .rd_en   (issue),
    .rd_data (in_rdata),
    .count   (in_count),
    .empty   (in_empty)
  );

  // Issue stage: holds the operands presented to the FPU for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_valid <= 1'b0;
      iss_a     <= '0;
      iss_b     <= '0;
      iss_op    <= '0;
      iss_tag   <= '0;
    end else begin
      iss_valid <= issue;
      if (issue) {iss_a, iss_b, iss_op, iss_tag} <= in_rdata;
    end
  end

  // Writeback stage: op/tag delayed one cycle to line up with fpu_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_op    <= '0;
      wb_tag   <= '0;
    end else begin
      wb_valid <= iss_valid;
      wb_op    <= iss_op;
      wb_tag   <= iss_tag;
    end
  end

  sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wb_valid),
    .wr_data ({fpu_out, wb_op, wb_tag}),
    .rd_en   (rsp_ready),
    .rd_data (out_rdata),
    .count   (out_count),
    .empty   (out_empty)
  );

  // FPU operands and response fields read as zero whenever their stage is idle.
  always_comb begin
    fpu_a      = '0;
    fpu_b      = '0;
    fpu_opcode = '0;
    rsp_data   = '0;
    rsp_op     = '0;
    rsp_tag    = '0;
    if (iss_valid) begin
      fpu_a      = iss_a;
      fpu_b      = iss_b;
      fpu_opcode = iss_op;
    end
    if (rsp_valid) {rsp_data, rsp_op, rsp_tag} = out_rdata;
  end

  assign busy = !in_empty || iss_valid || wb_valid || !out_empty;

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Self-checking bench for fpu_issue_queue with a behavioural registered FPU
// beside it and a scoreboard of expected responses in acceptance order.
module tb_fpu_issue_queue;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [1:0]  req_op;
  logic [3:0]  req_tag;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic [1:0]  fpu_opcode;
  logic [31:0] fpu_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_op;
  logic [3:0]  rsp_tag;
  logic        busy;

  int          checks   = 0;
  int          failures = 0;
  int          n_rsp    = 0;
  logic [63:0] sb[$];
  logic        hold_prev = 1'b0;
  logic [63:0] prev_rsp  = '0;

  fpu_issue_queue #(
    .IN_DEPTH (4),
    .TAG_W    (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .req_tag    (req_tag),
    .fpu_a      (fpu_a),
    .fpu_b      (fpu_b),
    .fpu_opcode (fpu_opcode),
    .fpu_out    (fpu_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_op     (rsp_op),
    .rsp_tag    (rsp_tag),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference FPU: exact IEEE results for the known vectors, a scrambling
  // function elsewhere so ordering and data-path faults remain visible.
  function automatic logic [31:0] fpu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
    if (a == 32'h3F800000 && b == 32'h40000000 && op == 2'd0) return 32'h40400000;
    if (a == 32'h40400000 && b == 32'h40000000) begin
      case (op)
        2'd0:    return 32'h40A00000;
        2'd1:    return 32'h3F800000;
        2'd2:    return 32'h40C00000;
        default: return 32'h3FC00000;
      endcase
    end
    return a ^ {b[15:0], b[31:16]} ^ {30'd0, op};
  endfunction

  function automatic logic [63:0] pack(input logic [31:0] d, input logic [1:0] op,
                                       input logic [3:0] tag);
    return {26'd0, d, op, tag};
  endfunction

  // External FPU: registered result one cycle after operands.
  always @(posedge clk) fpu_out <= fpu_ref(fpu_a, fpu_b, fpu_opcode);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: sampled mid-cycle, sees the handshakes that the next edge takes.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      hold_prev <= 1'b0;
    end else begin
      check("busy", 64'(busy), 64'(sb.size() != 0));
      if (hold_prev) check("rsp_stable", pack(rsp_data, rsp_op, rsp_tag), prev_rsp);
      if (req_valid && req_ready)
        sb.push_back(pack(fpu_ref(req_a, req_b, req_op), req_op, req_tag));
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 64'(rsp_valid), 64'd0);
        end else begin
          check("rsp", pack(rsp_data, rsp_op, rsp_tag), sb.pop_front());
          n_rsp <= n_rsp + 1;
        end
      end
      hold_prev <= rsp_valid && !rsp_ready;
      prev_rsp  <= pack(rsp_data, rsp_op, rsp_tag);
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                      input logic [3:0] tag);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    req_tag   = tag;
    for (int i = 0; i < 60; i++) begin
      if (req_ready) begin
        tick();
        req_valid = 1'b0;
        return;
      end
      tick();
    end
    check("send_timeout", 64'(req_ready), 64'd1);
    req_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0 && !busy) break;
      tick();
    end
    check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_fields"}, pack(rsp_data, rsp_op, rsp_tag), 64'd0);
    check({tag, "_fpu"}, {fpu_a, fpu_b[29:0], fpu_opcode}, 64'd0);
    check({tag, "_fpu_b"}, 64'(fpu_b), 64'd0);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_before;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    req_tag   = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    check_reset_outputs("init");
    rst = 1'b0;
    tick();
    check("ready_after_rst", 64'(req_ready), 64'd1);

    // Single ADD: response must appear exactly in cycle 4.
    rsp_ready = 1'b1;
    send(32'h3F800000, 32'h40000000, 2'd0, 4'd1);
    check("lat_c1", 64'(rsp_valid), 64'd0);
    tick();
    check("lat_c2", 64'(rsp_valid), 64'd0);
    check("fpu_a_issued", 64'(fpu_a), 64'h3F800000);
    tick();
    check("lat_c3", 64'(rsp_valid), 64'd0);
    tick();
    check("lat_c4", 64'(rsp_valid), 64'd1);
    check("lat_data", 64'(rsp_data), 64'h40400000);
    check("lat_tag", 64'(rsp_tag), 64'd1);
    drain("single");

    // Back-to-back four ops: responses on consecutive cycles.
    send(32'h40400000, 32'h40000000, 2'd0, 4'd2);
    send(32'h40400000, 32'h40000000, 2'd1, 4'd3);
    send(32'h40400000, 32'h40000000, 2'd2, 4'd4);
    send(32'h40400000, 32'h40000000, 2'd3, 4'd5);
    check("b2b_v0", {31'd0, rsp_valid, rsp_data}, {31'd0, 1'b1, 32'h40A00000});
    tick();
    check("b2b_v1", {31'd0, rsp_valid, rsp_data}, {31'd0, 1'b1, 32'h3F800000});
    tick();
    check("b2b_v2", {31'd0, rsp_valid, rsp_data}, {31'd0, 1'b1, 32'h40C00000});
    tick();
    check("b2b_v3", {31'd0, rsp_valid, rsp_data}, {31'd0, 1'b1, 32'h3FC00000});
    drain("b2b");

    // Blocked consumer: 7 accepted, 8th held off, then released in order.
    rsp_ready = 1'b0;
    for (int t = 0; t < 7; t++)
      send(32'h10000000 + 32'(t), 32'h20000000 + 32'(t * 3), 2'(t), 4'(t));
    req_valid = 1'b1;
    req_a     = 32'h12345678;
    req_b     = 32'h9ABCDEF0;
    req_op    = 2'd3;
    req_tag   = 4'd7;
    for (int i = 0; i < 5; i++) tick();
    check("blk_req_ready", 64'(req_ready), 64'd0);
    check("blk_in_count", 64'(dut.u_in_fifo.count), 64'd4);
    check("blk_out_count", 64'(dut.u_out_fifo.count), 64'd3);
    check("blk_head_tag", {31'd0, rsp_valid, 28'd0, rsp_tag}, {31'd0, 1'b1, 32'd0});
    rsp_ready = 1'b1;
    check("full_pop_ready_low", 64'(req_ready), 64'd0);
    tick();
    check("full_pop_ready_rise", 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
    drain("blk");

    // Random traffic with a randomly stalling consumer.
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          rsp_ready = 1'($urandom_range(0, 1));
          tick();
        end
        rsp_ready = 1'b1;
      end
      begin
        for (int t = 0; t < 24; t++) begin
          if ($urandom_range(0, 2) == 0) tick();
          send($urandom(), $urandom(), 2'($urandom_range(0, 3)), 4'(t));
        end
      end
    join
    rsp_ready = 1'b1;
    drain("rand");

    // Reset with operations in flight.
    send(32'h40400000, 32'h40000000, 2'd0, 4'd9);
    send(32'h40400000, 32'h40000000, 2'd1, 4'd10);
    send(32'h40400000, 32'h40000000, 2'd2, 4'd11);
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("post_rst_quiet", 64'(rsp_valid), 64'd0);
      tick();
    end
    n_before = n_rsp;
    send(32'h3F800000, 32'h40000000, 2'd0, 4'd12);
    drain("post_rst");
    check("post_rst_count", 64'(n_rsp), 64'(n_before + 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
